lcd_bus_master: RTL and testbench
=================================

# lcd_bus_master

Memory-bus initiator that drives the character LCD through the data-bus responder's LCD window: data register at 0xF000 and control register at 0xF001. It accepts byte commands over a valid/ready handshake and converts each into the bus-write sequence an HD44780-class panel needs: data, RS setup, E pulse, E release, then a settle wait. After reset it runs a fixed power-up initialisation before accepting commands. It sits between a text/console engine and the bus arbiter port shared with the CPU.

## Interface
Parameters:
- PWRUP_CYC, 2000000: idle cycles after reset before the first init command (40 ms at 50 MHz).
- EN_CYC, 25: cycles E is held high (minimum 1).
- CMD_CYC, 2500: settle cycles after a data write or an ordinary command.
- LONG_CYC, 80000: settle cycles after a command byte 0x01–0x03 (clear/home).

All four parameters must be below 2^24. They share one 24-bit down-counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- cmd_valid  in  1  command present.
- cmd_data  in  8  byte to send.
- cmd_rs  in  1  0 = instruction, 1 = character data.
- cmd_ready  out  1  block can accept a command.
- init_done  out  1  power-up sequence finished (sticky until reset).
- addr  out  32  bus address.
- write  out  16  bus write data.
- we  out  1  bus write enable.
- re  out  1  bus read enable; tied 0 (the LCD is write-only, RW is always 0).
- read  in  16  bus read data; ignored.
- ready  in  1  bus ready; a write completes on an edge where we && ready.

## Operation
- Control word written to 0xF001 is {13'b0, E, RW=0, RS}: bit2 = E, bit1 = RW, bit0 = RS.
- Reset values: cmd_ready = 0, init_done = 0, addr = 0, write = 0, we = 0, re = 0. State = PWRUP, counter = PWRUP_CYC.
- PWRUP: count down to 0, then load the init ROM index 0.
- Init ROM, all with RS = 0: 0x38, 0x0C, 0x01, 0x06.
  - Each init byte runs the send sequence below.
  - After the 4th byte's WAIT completes, set init_done and go to IDLE.
- IDLE: cmd_ready = 1. On cmd_valid && cmd_ready, latch cmd_data and cmd_rs, drop cmd_ready, and go to W_DATA. Inputs are not sampled outside IDLE.
- Send sequence:
  - W_DATA: addr = 0x0000F000, write = {8'h00, byte}, we = 1.
  - W_SETUP: addr = 0x0000F001, write = {13'b0, 3'b00, rs}, we = 1.
  - W_EN_HI: addr = 0x0000F001, write = {13'b0, 3'b10, rs}, we = 1.
  - PULSE: we = 0 for EN_CYC cycles.
  - W_EN_LO: same write as W_SETUP, we = 1.
  - WAIT: we = 0 for W cycles, where W = LONG_CYC if rs == 0 and byte is 0x01–0x03, otherwise CMD_CYC.
  - Then return to IDLE, or to the next init byte.
- Each W_* state advances only on an edge with ready = 1. While ready = 0, addr, write and we are held stable and no counter runs.
- In PULSE and WAIT: addr = 0, write = 0, we = 0.
- Reset mid-operation: the state returns to PWRUP on the same edge, we falls, and the latched command is discarded. The responder's LCD registers clear on the same rst.

## Timing
- With ready held at 1 and the command accepted on edge k:
  - we is high in cycles k+1..k+3.
  - PULSE occupies k+4..k+3+EN_CYC.
  - W_EN_LO is cycle k+4+EN_CYC.
  - WAIT occupies the next W cycles.
  - cmd_ready is 1 again in cycle k+5+EN_CYC+W.
- Each cycle that ready is low during a W_* state adds exactly one cycle.
- The first init write (W_DATA of 0x38) is in cycle PWRUP_CYC+1 after reset deasserts.
- init_done rises in the same cycle cmd_ready first rises.
- At most one command is in flight; there is no buffering.

## Test plan
- Init sequence (PWRUP_CYC = 10, EN_CYC = 2, CMD_CYC = 5, LONG_CYC = 20) -> bus writes appear in order:
  - F000 = 0x38, F001 = 0x0, F001 = 0x4, F001 = 0x0;
  - then the same pattern for 0x0C, 0x01 and 0x06;
  - gap after the 0x01 E-low write is 20 cycles, other gaps 5;
  - init_done and cmd_ready rise together.
- Character 'A' (cmd_data = 0x41, rs = 1) accepted at edge k -> writes:
  - F000 = 0x0041, F001 = 0x0001, F001 = 0x0005;
  - 2 idle cycles, then F001 = 0x0001;
  - cmd_ready returns in cycle k+12.
- Command 0x02 with rs = 0 -> LONG_CYC wait; command 0x80 -> CMD_CYC wait.
- ready held low for 3 cycles during W_EN_HI -> addr = F001, write = 0x5 and we stay stable; total latency grows by exactly 3.
- Reset asserted during PULSE -> we = 0 and cmd_ready = 0 next cycle; init restarts; an F001 = 0x0 write is issued only by the new init.
- cmd_valid held high with a new byte during WAIT -> not taken until cmd_ready = 1; back-to-back commands each take exactly 5+EN_CYC+W cycles.

Source files
------------

// File: rtl/lcd_bus_master.sv
// lcd_bus_master: turns byte commands into the bus-write sequence that drives
// an HD44780-class character LCD through the responder's LCD window
// (data register 0xF000, control register 0xF001). After reset it waits out
// the panel power-up time, then replays a fixed init sequence before it
// accepts commands. Control word layout: {13'b0, E, RW, RS}.
module lcd_bus_master #(
   parameter int PWRUP_CYC = 2000000,
   parameter int EN_CYC    = 25,
   parameter int CMD_CYC   = 2500,
   parameter int LONG_CYC  = 80000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   input  logic [7:0]  cmd_data,
   input  logic        cmd_rs,
   output logic        cmd_ready,
   output logic        init_done,
   output logic [31:0] addr,
   output logic [15:0] write,
   output logic        we,
   output logic        re,
   input  logic [15:0] read,
   input  logic        ready
);

   localparam logic [31:0] DATA_ADDR = 32'h0000_F000;
   localparam logic [31:0] CTRL_ADDR = 32'h0000_F001;

   // One shared 24-bit down-counter; PULSE and WAIT load length-1 so the
   // state lasts exactly the requested number of cycles.
   localparam logic [23:0] PWRUP_LD = 24'(PWRUP_CYC);
   localparam logic [23:0] EN_LD    = 24'(EN_CYC - 1);
   localparam logic [23:0] CMD_LD   = 24'(CMD_CYC - 1);
   localparam logic [23:0] LONG_LD  = 24'(LONG_CYC - 1);
   localparam bit          CMD_ZERO  = (CMD_CYC == 0);
   localparam bit          LONG_ZERO = (LONG_CYC == 0);

   typedef enum logic [2:0] {
      PWRUP,
      IDLE,
      W_DATA,
      W_SETUP,
      W_EN_HI,
      PULSE,
      W_EN_LO,
      WAIT
   } state_t;

   state_t      state, stateNext;
   logic [23:0] cnt, cntNext;
   logic [7:0]  byteQ, byteNext;
   logic        rsQ, rsNext;
   logic [1:0]  idx, idxNext, idxInc;
   logic        initMode, initModeNext;
   logic        initDone, initDoneNext;
   logic        isLong;
   logic        finish;

   // The LCD is write-only; the read bus is never consumed.
   logic unusedRead;
   assign unusedRead = ^read;

   function automatic logic [7:0] initRom(input logic [1:0] i);
      case (i)
         2'd0:    initRom = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
         2'd1:    initRom = 8'h0C;  // display on, cursor off
         2'd2:    initRom = 8'h01;  // clear display
         default: initRom = 8'h06;  // entry mode: increment, no shift
      endcase
   endfunction

   assign idxInc    = idx + 2'd1;
   // Clear and home commands need the long settle time.
   assign isLong    = !rsQ && (byteQ >= 8'h01) && (byteQ <= 8'h03);
   assign init_done = initDone;
   assign re        = 1'b0;

   // State register plus latched command, counter and init bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= PWRUP;
         cnt      <= PWRUP_LD;
         byteQ    <= 8'h00;
         rsQ      <= 1'b0;
         idx      <= 2'd0;
         initMode <= 1'b0;
         initDone <= 1'b0;
      end else begin
         state    <= stateNext;
         cnt      <= cntNext;
         byteQ    <= byteNext;
         rsQ      <= rsNext;
         idx      <= idxNext;
         initMode <= initModeNext;
         initDone <= initDoneNext;
      end
   end

   // Next-state logic and bus outputs; W_* states hold until the bus is ready.
   always_comb begin
      stateNext    = state;
      cntNext      = cnt;
      byteNext     = byteQ;
      rsNext       = rsQ;
      idxNext      = idx;
      initModeNext = initMode;
      initDoneNext = initDone;
      cmd_ready    = 1'b0;
      addr         = 32'h0;
      write        = 16'h0;
      we           = 1'b0;
      finish       = 1'b0;

      case (state)
         PWRUP: begin
            if (cnt == 24'd0) begin
               byteNext     = initRom(2'd0);
               rsNext       = 1'b0;
               idxNext      = 2'd0;
               initModeNext = 1'b1;
               stateNext    = W_DATA;
            end else begin
               cntNext = cnt - 24'd1;
            end
         end
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               byteNext  = cmd_data;
               rsNext    = cmd_rs;
               stateNext = W_DATA;
            end
         end
         W_DATA: begin
            addr  = DATA_ADDR;
            write = {8'h00, byteQ};
            we    = 1'b1;
            if (ready) stateNext = W_SETUP;
         end
         W_SETUP: begin
            addr  = CTRL_ADDR;
            write = {13'b0, 1'b0, 1'b0, rsQ};
            we    = 1'b1;
            if (ready) stateNext = W_EN_HI;
         end
         W_EN_HI: begin
            addr  = CTRL_ADDR;
            write = {13'b0, 1'b1, 1'b0, rsQ};
            we    = 1'b1;
            if (ready) begin
               cntNext   = EN_LD;
               stateNext = PULSE;
            end
         end
         PULSE: begin
            if (cnt == 24'd0) stateNext = W_EN_LO;
            else              cntNext   = cnt - 24'd1;
         end
         W_EN_LO: begin
            addr  = CTRL_ADDR;
            write = {13'b0, 1'b0, 1'b0, rsQ};
            we    = 1'b1;
            if (ready) begin
               // A zero-length settle skips WAIT entirely.
               if (isLong ? LONG_ZERO : CMD_ZERO) begin
                  finish = 1'b1;
               end else begin
                  cntNext   = isLong ? LONG_LD : CMD_LD;
                  stateNext = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == 24'd0) finish = 1'b1;
            else              cntNext = cnt - 24'd1;
         end
         default: stateNext = PWRUP;
      endcase

      // End of a send: next init byte, end of init, or back to IDLE.
      if (finish) begin
         if (initMode) begin
            if (idx == 2'd3) begin
               initModeNext = 1'b0;
               initDoneNext = 1'b1;
               stateNext    = IDLE;
            end else begin
               idxNext   = idxInc;
               byteNext  = initRom(idxInc);
               rsNext    = 1'b0;
               stateNext = W_DATA;
            end
         end else begin
            stateNext = IDLE;
         end
      end
   end

endmodule

// File: tb/tb_lcd_bus_master.sv
// Testbench for lcd_bus_master: scoreboard of expected bus writes filled when
// stimulus is driven and drained by a bus monitor, plus per-test timing checks.
module tb_lcd_bus_master;

   localparam int P    = 10;
   localparam int EN   = 2;
   localparam int CMD  = 5;
   localparam int LONG = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [7:0]  cmd_data = 8'h00;
   logic        cmd_rs = 1'b0;
   logic        ready = 1'b1;
   logic [15:0] read = 16'h0;
   logic        cmd_ready, init_done, we, re;
   logic [31:0] addr;
   logic [15:0] write;

   lcd_bus_master #(.PWRUP_CYC(P), .EN_CYC(EN), .CMD_CYC(CMD), .LONG_CYC(LONG)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_rs(cmd_rs),
      .cmd_ready(cmd_ready), .init_done(init_done), .addr(addr), .write(write),
      .we(we), .re(re), .read(read), .ready(ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] a;
      logic [15:0] d;
   } wr_t;

   wr_t expQ[$];
   int  wrCyc[$];

   // Bus monitor: every completed write is popped against the scoreboard;
   // cycles without a write must show an idle bus.
   always @(negedge clk) begin
      wr_t e;
      if (!rst) begin
         if (we === 1'b1 && ready === 1'b1) begin
            wrCyc.push_back(cyc);
            checks++;
            if (expQ.size() == 0) begin
               failures++;
               $display("FAIL bus_write unexpected addr=%h data=%h", addr, write);
            end else begin
               e = expQ.pop_front();
               if (addr !== e.a || write !== e.d) begin
                  failures++;
                  $display("FAIL bus_write got addr=%h data=%h expected addr=%h data=%h",
                           addr, write, e.a, e.d);
               end
            end
         end else if (we === 1'b0) begin
            checks++;
            if (addr !== 32'h0 || write !== 16'h0 || re !== 1'b0) begin
               failures++;
               $display("FAIL idle_bus got addr=%h data=%h re=%b expected 0/0/0", addr, write, re);
            end
         end
      end
   end

   task automatic push_send(input logic [7:0] b, input logic rs);
      expQ.push_back('{32'h0000_F000, {8'h00, b}});
      expQ.push_back('{32'h0000_F001, {15'h0, rs}});
      expQ.push_back('{32'h0000_F001, {13'h0, 3'b100} | {15'h0, rs}});
      expQ.push_back('{32'h0000_F001, {15'h0, rs}});
   endtask

   // Waits (bounded) for cmd_ready at a falling edge; lat = cycles since kc, -1 on timeout.
   task automatic wait_idle(input int kc, output int lat);
      lat = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (cmd_ready === 1'b1) begin
            lat = cyc - kc;
            break;
         end
      end
   endtask

   // Drives one command when the block is ready; kc is the cycle of the accepting edge.
   task automatic issue(input logic [7:0] b, input logic rs, output int kc);
      int lat;
      wait_idle(cyc, lat);
      kc = cyc;
      cmd_valid = 1'b1;
      cmd_data  = b;
      cmd_rs    = rs;
      push_send(b, rs);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0 || init_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags got cmd_ready=%b init_done=%b expected 0/0", cmd_ready, init_done);
      end
      checks++;
      if (we !== 1'b0 || re !== 1'b0 || addr !== 32'h0 || write !== 16'h0) begin
         failures++;
         $display("FAIL reset_bus got we=%b re=%b addr=%h data=%h expected all 0", we, re, addr, write);
      end
   endtask

   // Releases reset and checks the whole init sequence and its timing.
   task automatic test_init();
      int  c0;
      bit  got = 0;
      logic prevDone = 1'b0;
      expQ.delete();
      wrCyc.delete();
      push_send(8'h38, 1'b0);
      push_send(8'h0C, 1'b0);
      push_send(8'h01, 1'b0);
      push_send(8'h06, 1'b0);
      @(negedge clk);
      c0 = cyc;
      rst = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (cmd_ready === 1'b1) begin
            got = 1;
            break;
         end
         prevDone = init_done;
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL init_timeout cmd_ready never rose");
      end
      checks++;
      if (init_done !== 1'b1 || prevDone !== 1'b0) begin
         failures++;
         $display("FAIL init_done_edge got init_done=%b prev=%b expected 1/0", init_done, prevDone);
      end
      checks++;
      if (wrCyc.size() != 16) begin
         failures++;
         $display("FAIL init_write_count got %0d expected 16", wrCyc.size());
      end else begin
         checks++;
         if (wrCyc[0] - c0 != P + 1) begin
            failures++;
            $display("FAIL init_first_write got cycle %0d expected %0d", wrCyc[0] - c0, P + 1);
         end
         checks++;
         if (wrCyc[4] - wrCyc[3] != CMD + 1 || wrCyc[8] - wrCyc[7] != CMD + 1) begin
            failures++;
            $display("FAIL init_short_gap got %0d/%0d expected %0d", wrCyc[4] - wrCyc[3],
                     wrCyc[8] - wrCyc[7], CMD + 1);
         end
         checks++;
         if (wrCyc[12] - wrCyc[11] != LONG + 1) begin
            failures++;
            $display("FAIL init_clear_gap got %0d expected %0d", wrCyc[12] - wrCyc[11], LONG + 1);
         end
         checks++;
         if (cyc - wrCyc[15] != CMD + 1) begin
            failures++;
            $display("FAIL init_last_gap got %0d expected %0d", cyc - wrCyc[15], CMD + 1);
         end
      end
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("FAIL init_pending got %0d writes left expected 0", expQ.size());
      end
   endtask

   task automatic test_char();
      int kc, lat, n0;
      int expOff[4] = '{1, 2, 3, 6};
      n0 = wrCyc.size();
      issue(8'h41, 1'b1, kc);
      wait_idle(kc, lat);
      checks++;
      if (lat != 5 + EN + CMD) begin
         failures++;
         $display("FAIL char_latency got %0d expected %0d", lat, 5 + EN + CMD);
      end
      checks++;
      if (wrCyc.size() != n0 + 4) begin
         failures++;
         $display("FAIL char_write_count got %0d expected 4", wrCyc.size() - n0);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (wrCyc[n0 + i] - kc != expOff[i]) begin
               failures++;
               $display("FAIL char_write_time[%0d] got %0d expected %0d", i, wrCyc[n0 + i] - kc, expOff[i]);
            end
         end
      end
   endtask

   task automatic test_stall();
      int kc, lat, n0;
      n0 = wrCyc.size();
      issue(8'h42, 1'b1, kc);
      while (cyc < kc + 2) @(negedge clk);
      @(posedge clk);
      #1 ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (addr !== 32'h0000_F001 || write !== 16'h0005 || we !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold[%0d] got addr=%h data=%h we=%b expected 0000f001/0005/1",
                     i, addr, write, we);
         end
      end
      @(posedge clk);
      #1 ready = 1'b1;
      wait_idle(kc, lat);
      checks++;
      if (lat != 5 + EN + CMD + 3) begin
         failures++;
         $display("FAIL stall_latency got %0d expected %0d", lat, 5 + EN + CMD + 3);
      end
      checks++;
      if (wrCyc.size() != n0 + 4 || wrCyc[n0 + 2] - kc != 6) begin
         failures++;
         $display("FAIL stall_en_hi_time got count %0d expected 4 at offset 6", wrCyc.size() - n0);
      end
   endtask

   task automatic test_reset_pulse();
      int kc;
      issue(8'h41, 1'b1, kc);
      while (cyc < kc + 4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (we !== 1'b0 || cmd_ready !== 1'b0 || init_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_pulse got we=%b cmd_ready=%b init_done=%b expected 0/0/0",
                  we, cmd_ready, init_done);
      end
      test_init();
   endtask

   task automatic test_back_to_back();
      logic [7:0] tb[6] = '{8'h80, 8'h02, 8'h03, 8'h04, 8'h01, 8'h48};
      logic       tr[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      int         tw[6] = '{CMD, LONG, LONG, CMD, CMD, CMD};
      int kc, lat;
      wait_idle(cyc, lat);
      cmd_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cmd_data = tb[i];
         cmd_rs   = tr[i];
         push_send(tb[i], tr[i]);
         kc = cyc;
         @(posedge clk);
         // A different byte is left on the bus while busy; it must not be taken.
         #1 cmd_data = 8'hFF;
         cmd_rs = ~tr[i];
         wait_idle(kc, lat);
         checks++;
         if (lat != 5 + EN + tw[i]) begin
            failures++;
            $display("FAIL b2b_latency[%0d] byte=%h got %0d expected %0d", i, tb[i], lat, 5 + EN + tw[i]);
         end
      end
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("FAIL b2b_pending got %0d writes left expected 0", expQ.size());
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_char();
      test_stall();
      test_back_to_back();
      test_reset_pulse();
      test_char();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
